// File: rtl/sseg_scan_driver_if.sv
// +----------------------------------------------------------------------------+
// | sseg_scan_driver_if: value/control inputs and display outputs of the       |
// | seven-segment scan driver.                                                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface sseg_scan_driver_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   dp;
  logic                blank_lz;
  logic                en;
  logic [DIGITS-1:0]   an;
  logic [6:0]          sseg;
  logic                dp_n;
  logic                scan_tick;

  modport master (
    output value, dp, blank_lz, en,
    input  an, sseg, dp_n, scan_tick
  );

  modport slave (
    input  value, dp, blank_lz, en,
    output an, sseg, dp_n, scan_tick
  );
endinterface

`default_nettype wire

// File: rtl/sseg_scan_driver.sv
// +----------------------------------------------------------------------------+
// | sseg_scan_driver: time-multiplexed common-anode hex display driver with    |
// | frame-aligned snapshot, leading-zero blanking and global enable.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module sseg_scan_driver #(
  parameter int DIGITS = 4,
  parameter int DIV    = 100000
) (
  input  logic                clk,
  input  logic                reset_n,
  sseg_scan_driver_if.slave   bus
);

  localparam int               CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int               IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [6:0]       SEG_OFF  = 7'h7F;

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] snap_q, snap_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          sseg_q, sseg_d;
  logic                dpn_q, dpn_d;
  logic                tick_q;

  logic                w_tick;
  logic                w_blank;
  logic [3:0]          w_nib;
  logic [DIGITS-1:0]   w_upper_zero;

  function automatic logic [6:0] hex_seg(input logic [3:0] nib);
    case (nib)
      4'h0:    hex_seg = 7'h40;
      4'h1:    hex_seg = 7'h79;
      4'h2:    hex_seg = 7'h24;
      4'h3:    hex_seg = 7'h30;
      4'h4:    hex_seg = 7'h19;
      4'h5:    hex_seg = 7'h12;
      4'h6:    hex_seg = 7'h02;
      4'h7:    hex_seg = 7'h78;
      4'h8:    hex_seg = 7'h00;
      4'h9:    hex_seg = 7'h10;
      4'hA:    hex_seg = 7'h08;
      4'hB:    hex_seg = 7'h03;
      4'hC:    hex_seg = 7'h46;
      4'hD:    hex_seg = 7'h21;
      4'hE:    hex_seg = 7'h06;
      default: hex_seg = 7'h0E;
    endcase
  endfunction

  // w_upper_zero[i]: nibbles i..DIGITS-1 of the snapshot are all zero
  for (genvar i = 0; i < DIGITS; i++) begin : g_lz
    assign w_upper_zero[i] = ~|snap_q[4*DIGITS-1:4*i];
  end

  assign w_tick = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d  = w_tick ? '0 : cnt_q + 1'b1;
    idx_d  = idx_q;
    snap_d = snap_q;
    if (w_tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      // Latch a new value only at the frame wrap so a frame never tears
      if (idx_q == IDX_LAST) begin
        snap_d = bus.value;
      end
    end
  end

  always_comb begin
    w_nib   = snap_q[{idx_q, 2'b00} +: 4];
    w_blank = ~bus.en | (bus.blank_lz & (idx_q != '0) & w_upper_zero[idx_q]);
    an_d    = w_blank ? '1      : ~(DIGITS'(1) << idx_q);
    sseg_d  = w_blank ? SEG_OFF : hex_seg(w_nib);
    dpn_d   = w_blank ? 1'b1    : ~bus.dp[idx_q];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      snap_q <= '0;
      an_q   <= '1;
      sseg_q <= SEG_OFF;
      dpn_q  <= 1'b1;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      snap_q <= snap_d;
      an_q   <= an_d;
      sseg_q <= sseg_d;
      dpn_q  <= dpn_d;
      tick_q <= w_tick;
    end
  end

  assign bus.an        = an_q;
  assign bus.sseg      = sseg_q;
  assign bus.dp_n      = dpn_q;
  assign bus.scan_tick = tick_q;

endmodule

`default_nettype wire

// File: tb/tb_sseg_scan_driver.sv
// +----------------------------------------------------------------------------+
// | tb_sseg_scan_driver: directed scoreboard bench for sseg_scan_driver        |
// | (DIGITS=4, DIV=4). Revision: 1.0                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_sseg_scan_driver;

  logic clk;
  logic reset_n;
  int   total;
  int   passed;
  int   cyc;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] sseg;
    logic       dpn;
    logic       st;
  } exp_t;

  exp_t sb[$];

  sseg_scan_driver_if #(.DIGITS(4)) bus ();

  sseg_scan_driver #(
    .DIGITS (4),
    .DIV    (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
  endtask

  // Push the expected post-edge outputs, advance one clock, then pop and compare
  task automatic step(input logic [3:0] an, input logic [6:0] sg, input logic dpn, input logic st);
    exp_t e;
    sb.push_back('{an: an, sseg: sg, dpn: dpn, st: st});
    @(posedge clk);
    #1;
    cyc++;
    e = sb.pop_front();
    check("an",        32'(bus.an),        32'(e.an));
    check("sseg",      32'(bus.sseg),      32'(e.sseg));
    check("dp_n",      32'(bus.dp_n),      32'(e.dpn));
    check("scan_tick", 32'(bus.scan_tick), 32'(e.st));
  endtask

  // One digit slot: lit for 4 clocks, scan_tick on the last
  task automatic digit(input logic [3:0] an, input logic [6:0] sg, input logic dpn);
    step(an, sg, dpn, 1'b0);
    step(an, sg, dpn, 1'b0);
    step(an, sg, dpn, 1'b0);
    step(an, sg, dpn, 1'b1);
  endtask

  task automatic idle_check(input string tag);
    check({tag, "_an"},   32'(bus.an),        32'hF);
    check({tag, "_sseg"}, 32'(bus.sseg),      32'h7F);
    check({tag, "_dpn"},  32'(bus.dp_n),      32'h1);
    check({tag, "_st"},   32'(bus.scan_tick), 32'h0);
  endtask

  initial begin
    total        = 0;
    passed       = 0;
    cyc          = 0;
    reset_n      = 1'b0;
    bus.value    = 16'h12AF;
    bus.dp       = 4'b0100;
    bus.en       = 1'b1;
    bus.blank_lz = 1'b0;

    // Reset hold
    repeat (3) @(posedge clk);
    #1;
    idle_check("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // First frame shows the zero snapshot; second frame shows 12AF
    digit(4'hE, 7'h40, 1'b1);
    digit(4'hD, 7'h40, 1'b1);
    digit(4'hB, 7'h40, 1'b0);
    digit(4'h7, 7'h40, 1'b1);
    digit(4'hE, 7'h0E, 1'b1);
    digit(4'hD, 7'h08, 1'b1);
    digit(4'hB, 7'h24, 1'b0);
    digit(4'h7, 7'h79, 1'b1);

    // Leading-zero blanking: 12AF frame unaffected, then 0005, then 0000
    bus.blank_lz = 1'b1;
    bus.value    = 16'h0005;
    digit(4'hE, 7'h0E, 1'b1);
    digit(4'hD, 7'h08, 1'b1);
    digit(4'hB, 7'h24, 1'b0);
    digit(4'h7, 7'h79, 1'b1);
    bus.value = 16'h0000;
    digit(4'hE, 7'h12, 1'b1);
    digit(4'hF, 7'h7F, 1'b1);
    digit(4'hF, 7'h7F, 1'b1);
    digit(4'hF, 7'h7F, 1'b1);
    bus.value = 16'h1111;
    digit(4'hE, 7'h40, 1'b1);
    digit(4'hF, 7'h7F, 1'b1);
    digit(4'hF, 7'h7F, 1'b1);
    digit(4'hF, 7'h7F, 1'b1);

    // Mid-frame value change must not tear the 1111 frame
    bus.blank_lz = 1'b0;
    digit(4'hE, 7'h79, 1'b1);
    step(4'hD, 7'h79, 1'b1, 1'b0);
    bus.value = 16'h2222;
    step(4'hD, 7'h79, 1'b1, 1'b0);
    step(4'hD, 7'h79, 1'b1, 1'b0);
    step(4'hD, 7'h79, 1'b1, 1'b1);
    digit(4'hB, 7'h79, 1'b0);
    digit(4'h7, 7'h79, 1'b1);

    // Enable off for 6 cycles mid-digit; scan timing unaffected
    step(4'hE, 7'h24, 1'b1, 1'b0);
    step(4'hE, 7'h24, 1'b1, 1'b0);
    bus.en = 1'b0;
    step(4'hF, 7'h7F, 1'b1, 1'b0);
    step(4'hF, 7'h7F, 1'b1, 1'b1);
    step(4'hF, 7'h7F, 1'b1, 1'b0);
    step(4'hF, 7'h7F, 1'b1, 1'b0);
    step(4'hF, 7'h7F, 1'b1, 1'b0);
    step(4'hF, 7'h7F, 1'b1, 1'b1);
    bus.en = 1'b1;
    digit(4'hB, 7'h24, 1'b0);
    digit(4'h7, 7'h24, 1'b1);

    // Asynchronous reset pulse between edges, mid digit 0
    step(4'hE, 7'h24, 1'b1, 1'b0);
    step(4'hE, 7'h24, 1'b1, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    idle_check("async_rst");
    #2;
    reset_n = 1'b1;
    digit(4'hE, 7'h40, 1'b1);
    digit(4'hD, 7'h40, 1'b1);
    digit(4'hB, 7'h40, 1'b0);
    digit(4'h7, 7'h40, 1'b1);
    digit(4'hE, 7'h24, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
